mudi_sequencer: RTL and testbench
=================================

// Module: mudi_sequencer
// PURPOSE
//  Sequences the shared multiply/divide unit (MUDI) in the E stage of the 5-stage MIPS pipeline.
//  - Latches operands on a start pulse and runs a fixed-latency busy countdown.
//  - Commits HI/LO when the countdown ends.
//  - Serves mfhi/mflo reads and raises the D-stage stall for MUDI-dependent instructions.
// PARAMETERS
//  MULT_CYC  5   busy cycles for mult/multu (>=1)
//  DIV_CYC   10  busy cycles for div/divu (>=1)
//  FDIV_CYC  10  busy cycles for fdiv (>=1)
// PORTS
//  clk        in   1   single clock, all state changes on posedge
//  reset      in   1   synchronous, active-high
//  start      in   1   E-stage instr is mult/multu/div/divu/mthi/mtlo/fdiv (isStart)
//  mudi_op    in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 fdiv, 111 rsvd
//  rs_val     in   32  forwarded rs operand, E stage
//  rt_val     in   32  forwarded rt operand, E stage
//  sel_hi     in   1   read select: 1 HI, 0 LO (MUDI_sel)
//  d_md_use   in   1   D-stage instr is start-type or mfhi/mflo
//  busy       out  1   countdown in progress
//  stall      out  1   D-stage stall request
//  hi         out  32  committed HI
//  lo         out  32  committed LO
//  md_out     out  32  sel_hi ? hi : lo
//  err        out  1   sticky: start seen while busy, or op 111
// BEHAVIOUR
//  - Reset (sync, dominates start): state IDLE; cnt=0; hi=0, lo=0; busy=0; err=0; pending result discarded.
//  - States: IDLE (cnt==0), BUSY (cnt!=0); busy = (cnt!=0); stall = d_md_use & (start | busy).
//  - IDLE + start, op mult/multu/div/divu/fdiv, edge T:
//    - latch rs/rt and op; cnt <= N (MULT_CYC / DIV_CYC / FDIV_CYC).
//    - busy is high in cycles T+1..T+N.
//  - BUSY: cnt decrements each edge. On the edge where cnt==1, the pending result is written to HI/LO and cnt->0.
//    - New HI/LO is visible in cycle T+N+1, the first cycle with busy=0.
//  - mthi/mtlo in IDLE: hi<=rs_val or lo<=rs_val at the start edge; no busy cycles; visible next cycle.
//  - Arithmetic on latched operands:
//    - mult: signed 64-bit product. multu: unsigned 64-bit product. Both give {hi,lo}=product.
//    - div: signed; lo=quotient truncated toward 0; hi=remainder with the dividend's sign.
//    - divu: unsigned lo=quotient, hi=remainder.
//    - fdiv: unsigned Q16.16 divide; lo=({rs,16'h0}/{16'h0,rt})[31:0]; hi=remainder[31:0].
//  - Divisor 0 (div/divu/fdiv): all busy cycles still run; hi/lo are NOT written at the end.
//  - start while BUSY: ignored (no restart, operands kept); err<=1. Cannot occur if stall is honored.
//  - op 111 with start: no action; err<=1.
//  - err clears only on reset.
//  - md_out is combinational from the committed hi/lo. It never shows in-flight results.
//  - A read during BUSY is a stall violation; md_out returns the old value.
//  - reset during BUSY: cycle aborted; hi/lo=0 next cycle.
// TESTING
//  - rs=FFFFFFFD, rt=5, mult -> busy for 5 cycles; then hi=FFFFFFFF, lo=FFFFFFF1.
//  - rs=FFFFFFF9, rt=2, div -> after 10 cycles lo=FFFFFFFD, hi=FFFFFFFF. Same operands with divu -> lo=7FFFFFFC, hi=1.
//  - rs=1, rt=2, fdiv -> lo=00008000, hi=0.
//  - mthi rs=12345678, then sel_hi=1 -> md_out=12345678 next cycle, busy stays 0.
//  - mult issued with d_md_use=1 held -> stall=1 in the start cycle plus 5 busy cycles, stall=0 after.
//    divu by 0 -> hi/lo unchanged.
//  - reset asserted in the 3rd busy cycle of div -> next cycle busy=0, hi=lo=0, err=0.
//    start during busy -> err=1 and the original result still commits.

Source files
------------

// File: rtl/mudi_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mudi_sequencer_if
// Brief    : E-stage handshake and result bus between the pipeline and the
//            multiply/divide sequencer.
// Revision : 1.0
// ============================================================================
interface mudi_sequencer_if;
  logic        start;
  logic [2:0]  mudi_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        sel_hi;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;
  logic        err;

  // Pipeline side: issues operations and reads results
  modport master (
    output start, mudi_op, rs_val, rt_val, sel_hi, d_md_use,
    input  busy, stall, hi, lo, md_out, err
  );

  // Sequencer side
  modport slave (
    input  start, mudi_op, rs_val, rt_val, sel_hi, d_md_use,
    output busy, stall, hi, lo, md_out, err
  );
endinterface
`default_nettype wire

// File: rtl/mudi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mudi_sequencer
// Brief    : Shared multiply/divide unit sequencer for the E stage. Latches
//            operands on start, counts down a fixed latency, then commits
//            HI/LO. Serves mfhi/mflo reads and raises the D-stage stall.
// Revision : 1.0
// ============================================================================
module mudi_sequencer #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int FDIV_CYC = 10
) (
  input  logic            clk,
  input  logic            reset,
  mudi_sequencer_if.slave bus
);

  localparam int c_MAX_CYC = (MULT_CYC > DIV_CYC)
                             ? ((MULT_CYC > FDIV_CYC) ? MULT_CYC : FDIV_CYC)
                             : ((DIV_CYC  > FDIV_CYC) ? DIV_CYC  : FDIV_CYC);
  localparam int c_CNT_W = $clog2(c_MAX_CYC + 1);

  localparam logic [c_CNT_W-1:0] c_MULT_N = c_CNT_W'(MULT_CYC);
  localparam logic [c_CNT_W-1:0] c_DIV_N  = c_CNT_W'(DIV_CYC);
  localparam logic [c_CNT_W-1:0] c_FDIV_N = c_CNT_W'(FDIV_CYC);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MTHI  = 3'b100;
  localparam logic [2:0] c_OP_MTLO  = 3'b101;
  localparam logic [2:0] c_OP_FDIV  = 3'b110;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_op;
  logic [31:0]        r_rs;
  logic [31:0]        r_rt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic               r_err;

  logic [31:0]        w_rtSafe;
  logic signed [63:0] w_prodS;
  logic [63:0]        w_prodU;
  logic signed [31:0] w_quotS;
  logic signed [31:0] w_remS;
  logic [31:0]        w_quotU;
  logic [31:0]        w_remU;
  logic [31:0]        w_fQuot;
  logic [31:0]        w_fRem;
  logic               w_divZero;
  logic [31:0]        w_resHi;
  logic [31:0]        w_resLo;

  // Result datapath on the latched operands; divisor forced to 1 when zero so
  // the dividers never see 0 (the commit is suppressed in that case anyway)
  always_comb begin
    w_rtSafe  = (r_rt == 32'd0) ? 32'd1 : r_rt;
    w_prodS   = $signed({{32{r_rs[31]}}, r_rs}) * $signed({{32{r_rt[31]}}, r_rt});
    w_prodU   = {32'd0, r_rs} * {32'd0, r_rt};
    w_quotS   = $signed(r_rs) / $signed(w_rtSafe);
    w_remS    = $signed(r_rs) % $signed(w_rtSafe);
    w_quotU   = r_rs / w_rtSafe;
    w_remU    = r_rs % w_rtSafe;
    w_fQuot   = 32'({r_rs, 16'h0000} / {16'h0000, w_rtSafe});
    w_fRem    = 32'({r_rs, 16'h0000} % {16'h0000, w_rtSafe});
    w_divZero = 1'b0;
    w_resHi   = r_hi;
    w_resLo   = r_lo;
    case (r_op)
      c_OP_MULT: begin
        w_resHi = w_prodS[63:32];
        w_resLo = w_prodS[31:0];
      end
      c_OP_MULTU: begin
        w_resHi = w_prodU[63:32];
        w_resLo = w_prodU[31:0];
      end
      c_OP_DIV: begin
        w_divZero = (r_rt == 32'd0);
        w_resHi   = w_remS;
        w_resLo   = w_quotS;
      end
      c_OP_DIVU: begin
        w_divZero = (r_rt == 32'd0);
        w_resHi   = w_remU;
        w_resLo   = w_quotU;
      end
      c_OP_FDIV: begin
        w_divZero = (r_rt == 32'd0);
        w_resHi   = w_fRem;
        w_resLo   = w_fQuot;
      end
      default: begin
        w_divZero = 1'b0;
      end
    endcase
  end

  // Sequencer FSM: accept ops in IDLE, count down in BUSY, commit on the last edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 3'b000;
      r_rs    <= 32'd0;
      r_rt    <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.mudi_op)
              c_OP_MULT, c_OP_MULTU: begin
                r_rs    <= bus.rs_val;
                r_rt    <= bus.rt_val;
                r_op    <= bus.mudi_op;
                r_cnt   <= c_MULT_N;
                r_state <= S_BUSY;
              end
              c_OP_DIV, c_OP_DIVU: begin
                r_rs    <= bus.rs_val;
                r_rt    <= bus.rt_val;
                r_op    <= bus.mudi_op;
                r_cnt   <= c_DIV_N;
                r_state <= S_BUSY;
              end
              c_OP_FDIV: begin
                r_rs    <= bus.rs_val;
                r_rt    <= bus.rt_val;
                r_op    <= bus.mudi_op;
                r_cnt   <= c_FDIV_N;
                r_state <= S_BUSY;
              end
              c_OP_MTHI: r_hi  <= bus.rs_val;
              c_OP_MTLO: r_lo  <= bus.rs_val;
              default:   r_err <= 1'b1;
            endcase
          end
        end
        S_BUSY: begin
          // A start here means the stall was ignored; keep running, flag it
          if (bus.start) begin
            r_err <= 1'b1;
          end
          r_cnt <= r_cnt - c_ONE;
          if (r_cnt == c_ONE) begin
            r_state <= S_IDLE;
            if (!w_divZero) begin
              r_hi <= w_resHi;
              r_lo <= w_resLo;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state == S_BUSY);
  assign bus.stall  = bus.d_md_use & (bus.start | (r_state == S_BUSY));
  assign bus.hi     = r_hi;
  assign bus.lo     = r_lo;
  assign bus.md_out = bus.sel_hi ? r_hi : r_lo;
  assign bus.err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mudi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mudi_sequencer
// Brief    : Self-checking bench for mudi_sequencer: directed cases plus
//            random operations against an arithmetic reference model, with a
//            commit scoreboard checked by an independent monitor.
// Revision : 1.0
// ============================================================================
module tb_mudi_sequencer;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
  localparam int FDIV_CYC = 10;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_FDIV  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          tests = 0;
  int          fails = 0;
  logic [63:0] expQ[$];
  logic [63:0] monE;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;
  logic        errExp = 1'b0;
  logic        prevBusy = 1'b0;

  mudi_sequencer_if bus();

  mudi_sequencer #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC),
    .FDIV_CYC(FDIV_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int latency(input logic [2:0] op);
    case (op)
      OP_MULT, OP_MULTU: return MULT_CYC;
      OP_DIV, OP_DIVU:   return DIV_CYC;
      OP_FDIV:           return FDIV_CYC;
      default:           return 0;
    endcase
  endfunction

  // Reference result {hi,lo} from plain 64-bit arithmetic
  function automatic logic [63:0] refRes(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = 64'(a);
    ub  = 64'(b);
    res = {mHi, mLo};
    case (op)
      OP_MULT:  res = 64'(sa * sb);
      OP_MULTU: res = ua * ub;
      OP_DIV: if (b != 32'd0) begin
        sq = sa / sb; sr = sa % sb;
        res = {sr[31:0], sq[31:0]};
      end
      OP_DIVU: if (b != 32'd0) begin
        uq = ua / ub; ur = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
      OP_FDIV: if (b != 32'd0) begin
        uq = (ua << 16) / ub; ur = (ua << 16) % ub;
        res = {ur[31:0], uq[31:0]};
      end
      default: res = {mHi, mLo};
    endcase
    return res;
  endfunction

  // Monitor: every busy 1->0 transition is a commit; compare with scoreboard
  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
      prevBusy = 1'b0;
    end else begin
      if (prevBusy && !bus.busy) begin
        if (expQ.size() == 0) begin
          chk("unexpectedCommit", 64'(1), 64'(0));
        end else begin
          monE = expQ.pop_front();
          chk("commitHi", 64'(bus.hi), 64'(monE[63:32]));
          chk("commitLo", 64'(bus.lo), 64'(monE[31:0]));
          chk("commitMdOut", 64'(bus.md_out), 64'(bus.sel_hi ? monE[63:32] : monE[31:0]));
        end
      end
      prevBusy = bus.busy;
    end
  end

  // Issue one start-type op and follow it to completion
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          n;
    int          busyCnt;
    logic [63:0] r;
    n = latency(op);
    bus.start   = 1'b1;
    bus.mudi_op = op;
    bus.rs_val  = a;
    bus.rt_val  = b;
    @(negedge clk);
    chk("stallStart", 64'(bus.stall), 64'(bus.d_md_use));
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (n > 0) begin
      r = refRes(op, a, b);
      expQ.push_back(r);
      mHi = r[63:32];
      mLo = r[31:0];
      busyCnt = 0;
      for (int k = 0; k < 64; k++) begin
        @(negedge clk);
        if (!bus.busy) break;
        busyCnt++;
        chk("stallBusy", 64'(bus.stall), 64'(bus.d_md_use));
      end
      chk("busyLen", 64'(busyCnt), 64'(n));
      chk("stallAfter", 64'(bus.stall), 64'(0));
      chk("errAfterOp", 64'(bus.err), 64'(errExp));
    end else begin
      if (op == OP_MTHI) mHi = a;
      else if (op == OP_MTLO) mLo = a;
      else errExp = 1'b1;
      @(negedge clk);
      chk("moveHi", 64'(bus.hi), 64'(mHi));
      chk("moveLo", 64'(bus.lo), 64'(mLo));
      chk("moveBusy", 64'(bus.busy), 64'(0));
      chk("moveErr", 64'(bus.err), 64'(errExp));
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [31:0] savedHi, savedLo, a, b;
    logic [2:0]  op;
    int          busyCnt;
    bus.start    = 1'b0;
    bus.mudi_op  = 3'd0;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
    bus.sel_hi   = 1'b0;
    bus.d_md_use = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstHi", 64'(bus.hi), 64'(0));
    chk("rstLo", 64'(bus.lo), 64'(0));
    chk("rstBusy", 64'(bus.busy), 64'(0));
    chk("rstErr", 64'(bus.err), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // mult with a dependent D-stage instruction held
    bus.d_md_use = 1'b1;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
    bus.d_md_use = 1'b0;
    chk("multHi", 64'(bus.hi), 64'(32'hFFFFFFFF));
    chk("multLo", 64'(bus.lo), 64'(32'hFFFFFFF1));

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    chk("divLo", 64'(bus.lo), 64'(32'hFFFFFFFD));
    chk("divHi", 64'(bus.hi), 64'(32'hFFFFFFFF));
    issue(OP_DIVU, 32'hFFFFFFF9, 32'd2);
    chk("divuLo", 64'(bus.lo), 64'(32'h7FFFFFFC));
    chk("divuHi", 64'(bus.hi), 64'(32'h00000001));
    issue(OP_FDIV, 32'd1, 32'd2);
    chk("fdivLo", 64'(bus.lo), 64'(32'h00008000));
    chk("fdivHi", 64'(bus.hi), 64'(32'h00000000));

    bus.sel_hi = 1'b1;
    issue(OP_MTHI, 32'h12345678, 32'd0);
    chk("mthiMdOut", 64'(bus.md_out), 64'(32'h12345678));
    bus.sel_hi = 1'b0;

    // Zero divisor leaves HI/LO untouched
    savedHi = bus.hi;
    savedLo = bus.lo;
    issue(OP_DIVU, 32'd5, 32'd0);
    chk("div0Hi", 64'(bus.hi), 64'(savedHi));
    chk("div0Lo", 64'(bus.lo), 64'(savedLo));

    // Reserved opcode sets the sticky error
    issue(OP_RSVD, 32'hDEADBEEF, 32'd1);

    // Reset in the third busy cycle of a div aborts it and clears err
    bus.start = 1'b1; bus.mudi_op = OP_DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abortBusy", 64'(bus.busy), 64'(0));
    chk("abortHi", 64'(bus.hi), 64'(0));
    chk("abortLo", 64'(bus.lo), 64'(0));
    chk("abortErr", 64'(bus.err), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    mHi = 32'd0; mLo = 32'd0; errExp = 1'b0;

    // Start during busy: ignored, err set, original mult still commits
    bus.start = 1'b1; bus.mudi_op = OP_MULT; bus.rs_val = 32'd7; bus.rt_val = 32'd6;
    expQ.push_back(refRes(OP_MULT, 32'd7, 32'd6));
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mudi_op = OP_DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    errExp = 1'b1;
    busyCnt = 0;
    while (bus.busy && busyCnt < 64) begin
      @(posedge clk); #1;
      busyCnt++;
    end
    chk("conflictDone", 64'(bus.busy), 64'(0));
    chk("conflictErr", 64'(bus.err), 64'(1));
    chk("conflictHi", 64'(bus.hi), 64'(0));
    chk("conflictLo", 64'(bus.lo), 64'(42));
    mHi = 32'd0; mLo = 32'd42;

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 6));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = $urandom;
        default: b = 32'hFFFFFFFF;
      endcase
      if (op == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) a = 32'h80000001;
      bus.sel_hi   = 1'($urandom_range(0, 1));
      bus.d_md_use = 1'($urandom_range(0, 1));
      issue(op, a, b);
      chk("randHi", 64'(bus.hi), 64'(mHi));
      chk("randLo", 64'(bus.lo), 64'(mLo));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queueEmpty", 64'(expQ.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
